// File: rtl/press_race_arbiter.sv
// press_race_arbiter: N-player first-press arbiter with false-start lockout
// and a saturating reaction-time counter. All outputs are registered.
module press_race_arbiter #(
    parameter int unsigned NPLAYERS    = 2,
    parameter int unsigned IDXW        = 1,
    parameter int unsigned TW          = 8,
    parameter bit          FALSE_START = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                arm,
    input  logic [NPLAYERS-1:0] pb,
    output logic                winrnd,
    output logic                tie,
    output logic [IDXW-1:0]     winner,
    output logic [NPLAYERS-1:0] winmask,
    output logic [NPLAYERS-1:0] foul,
    output logic                armed,
    output logic [TW-1:0]       react
);

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [NPLAYERS-1:0] pb_q;
    logic                winrnd_q, winrnd_d;
    logic                tie_q, tie_d;
    logic [IDXW-1:0]     winner_q, winner_d;
    logic [NPLAYERS-1:0] winmask_q, winmask_d;
    logic [NPLAYERS-1:0] foul_q, foul_d;
    logic                armed_q;
    logic [TW-1:0]       react_q, react_d;

    logic [NPLAYERS-1:0] press;
    logic [NPLAYERS-1:0] valid;
    logic                multi;
    logic [IDXW-1:0]     low_idx;
    logic [TW-1:0]       react_inc;

    // Edge detect, lockout masking and lowest-index priority encode.
    always_comb begin
        press     = pb & ~pb_q;
        valid     = press & ~foul_q;
        // More than one bit set iff clearing the lowest set bit leaves something.
        multi     = |(valid & (valid - 1'b1));
        react_inc = (react_q == {TW{1'b1}}) ? react_q : react_q + 1'b1;
        low_idx   = '0;
        for (int i = int'(NPLAYERS) - 1; i >= 0; i--) begin
            if (valid[i]) begin
                low_idx = IDXW'(i);
            end
        end
    end

    // Round state machine: next-state and next-output computation.
    always_comb begin
        state_d   = state_q;
        winrnd_d  = winrnd_q;
        tie_d     = tie_q;
        winner_d  = winner_q;
        winmask_d = winmask_q;
        foul_d    = foul_q;
        react_d   = react_q;

        if (clr) begin
            state_d   = StIdle;
            winrnd_d  = 1'b0;
            tie_d     = 1'b0;
            winner_d  = '0;
            winmask_d = '0;
            foul_d    = '0;
            react_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // A press coincident with arm still counts as a false start.
                    if (FALSE_START) begin
                        foul_d = foul_q | press;
                    end
                    if (arm) begin
                        state_d = StArmed;
                        react_d = '0;
                    end
                end
                StArmed: begin
                    react_d = react_inc;
                    if (valid != '0) begin
                        state_d   = StDone;
                        winmask_d = valid;
                        winrnd_d  = ~multi;
                        tie_d     = multi;
                        winner_d  = low_idx;
                    end
                end
                StDone: begin
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and output registers; pb_q resets high so a held button is not a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pb_q      <= {NPLAYERS{1'b1}};
            winrnd_q  <= 1'b0;
            tie_q     <= 1'b0;
            winner_q  <= '0;
            winmask_q <= '0;
            foul_q    <= '0;
            armed_q   <= 1'b0;
            react_q   <= '0;
        end else begin
            state_q   <= state_d;
            pb_q      <= pb;
            winrnd_q  <= winrnd_d;
            tie_q     <= tie_d;
            winner_q  <= winner_d;
            winmask_q <= winmask_d;
            foul_q    <= foul_d;
            armed_q   <= (state_d == StArmed);
            react_q   <= react_d;
        end
    end

    assign winrnd  = winrnd_q;
    assign tie     = tie_q;
    assign winner  = winner_q;
    assign winmask = winmask_q;
    assign foul    = foul_q;
    assign armed   = armed_q;
    assign react   = react_q;

endmodule

// File: tb/tb_press_race_arbiter.sv
// Testbench for press_race_arbiter: table of per-cycle vectors plus
// hand-written saturation and asynchronous-reset sequences.
module tb_press_race_arbiter;

    localparam int unsigned NP = 4;

    typedef struct packed {
        logic       winrnd;
        logic       tie;
        logic [1:0] winner;
        logic [3:0] winmask;
        logic [3:0] foul;
        logic       armed;
        logic [7:0] react;
    } exp_t;

    typedef struct packed {
        logic       clr;
        logic       arm;
        logic [3:0] pb;
        exp_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       arm;
    logic [3:0] pb;
    logic       winrnd;
    logic       tie;
    logic [1:0] winner;
    logic [3:0] winmask;
    logic [3:0] foul;
    logic       armed;
    logic [7:0] react;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];
    vec_t tbl[$];

    press_race_arbiter #(
        .NPLAYERS   (NP),
        .IDXW       (2),
        .TW         (8),
        .FALSE_START(1'b1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .arm    (arm),
        .pb     (pb),
        .winrnd (winrnd),
        .tie    (tie),
        .winner (winner),
        .winmask(winmask),
        .foul   (foul),
        .armed  (armed),
        .react  (react)
    );

    always #5 clk = ~clk;

    function automatic exp_t e(bit w, bit t, logic [1:0] wi, logic [3:0] m, logic [3:0] f,
                               bit ar, logic [7:0] r);
        exp_t x;
        x.winrnd  = w;
        x.tie     = t;
        x.winner  = wi;
        x.winmask = m;
        x.foul    = f;
        x.armed   = ar;
        x.react   = r;
        return x;
    endfunction

    function automatic vec_t v(bit c, bit a, logic [3:0] p, exp_t x);
        vec_t r;
        r.clr = c;
        r.arm = a;
        r.pb  = p;
        r.exp = x;
        return r;
    endfunction

    function automatic exp_t observed();
        return e(winrnd, tie, winner, winmask, foul, armed, react);
    endfunction

    task automatic compare(input string name, input exp_t want);
        exp_t got;
        got = observed();
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got w=%b t=%b idx=%0d mask=%b foul=%b armed=%b react=%0d, want w=%b t=%b idx=%0d mask=%b foul=%b armed=%b react=%0d",
                     name, got.winrnd, got.tie, got.winner, got.winmask, got.foul, got.armed,
                     got.react, want.winrnd, want.tie, want.winner, want.winmask, want.foul,
                     want.armed, want.react);
        end
    endtask

    // Drive one cycle of stimulus (called just after a rising edge), push the
    // expectation, then pop and check it just after the next rising edge.
    task automatic step(input string name, input logic c, input logic a, input logic [3:0] p,
                        input exp_t want);
        exp_t x;
        clr = c;
        arm = a;
        pb  = p;
        sb_q.push_back(want);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            x = sb_q.pop_front();
            compare(name, x);
        end
    endtask

    localparam exp_t Z = '0;

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        arm = 1'b0;
        pb  = 4'b0001;

        // Reset / held button
        tbl.push_back(v(0, 0, 4'b0001, Z));
        tbl.push_back(v(0, 1, 4'b0001, e(0, 0, 0, 4'b0000, 4'b0000, 1, 0)));
        tbl.push_back(v(0, 0, 4'b0001, e(0, 0, 0, 4'b0000, 4'b0000, 1, 1)));
        tbl.push_back(v(0, 0, 4'b0000, e(0, 0, 0, 4'b0000, 4'b0000, 1, 2)));
        tbl.push_back(v(0, 0, 4'b0001, e(1, 0, 0, 4'b0001, 4'b0000, 0, 3)));
        tbl.push_back(v(1, 0, 4'b0000, Z));
        // Single winner at A+3, later press ignored
        tbl.push_back(v(0, 1, 4'b0000, e(0, 0, 0, 4'b0000, 4'b0000, 1, 0)));
        tbl.push_back(v(0, 0, 4'b0000, e(0, 0, 0, 4'b0000, 4'b0000, 1, 1)));
        tbl.push_back(v(0, 0, 4'b0000, e(0, 0, 0, 4'b0000, 4'b0000, 1, 2)));
        tbl.push_back(v(0, 0, 4'b0100, e(1, 0, 2, 4'b0100, 4'b0000, 0, 3)));
        tbl.push_back(v(0, 0, 4'b0110, e(1, 0, 2, 4'b0100, 4'b0000, 0, 3)));
        tbl.push_back(v(1, 0, 4'b0000, Z));
        // Tie, then arm in DONE ignored
        tbl.push_back(v(0, 1, 4'b0000, e(0, 0, 0, 4'b0000, 4'b0000, 1, 0)));
        tbl.push_back(v(0, 0, 4'b1010, e(0, 1, 1, 4'b1010, 4'b0000, 0, 1)));
        tbl.push_back(v(0, 1, 4'b0000, e(0, 1, 1, 4'b1010, 4'b0000, 0, 1)));
        tbl.push_back(v(1, 0, 4'b0000, Z));
        // False start on player 0
        tbl.push_back(v(0, 0, 4'b0001, e(0, 0, 0, 4'b0000, 4'b0001, 0, 0)));
        tbl.push_back(v(0, 0, 4'b0000, e(0, 0, 0, 4'b0000, 4'b0001, 0, 0)));
        tbl.push_back(v(0, 1, 4'b0000, e(0, 0, 0, 4'b0000, 4'b0001, 1, 0)));
        tbl.push_back(v(0, 0, 4'b0001, e(0, 0, 0, 4'b0000, 4'b0001, 1, 1)));
        tbl.push_back(v(0, 0, 4'b0000, e(0, 0, 0, 4'b0000, 4'b0001, 1, 2)));
        tbl.push_back(v(0, 0, 4'b1000, e(1, 0, 3, 4'b1000, 4'b0001, 0, 3)));
        tbl.push_back(v(1, 0, 4'b0000, Z));
        // Press coincident with arm is a foul
        tbl.push_back(v(0, 1, 4'b0100, e(0, 0, 0, 4'b0000, 4'b0100, 1, 0)));
        tbl.push_back(v(0, 0, 4'b0000, e(0, 0, 0, 4'b0000, 4'b0100, 1, 1)));
        tbl.push_back(v(1, 0, 4'b0000, Z));
        // Clear priority over press, and over arm
        tbl.push_back(v(0, 1, 4'b0000, e(0, 0, 0, 4'b0000, 4'b0000, 1, 0)));
        tbl.push_back(v(0, 0, 4'b0000, e(0, 0, 0, 4'b0000, 4'b0000, 1, 1)));
        tbl.push_back(v(1, 0, 4'b0100, Z));
        tbl.push_back(v(1, 1, 4'b0000, Z));
        tbl.push_back(v(0, 0, 4'b0000, Z));
        // Every player fouled: stays ARMED
        tbl.push_back(v(0, 0, 4'b1111, e(0, 0, 0, 4'b0000, 4'b1111, 0, 0)));
        tbl.push_back(v(0, 1, 4'b0000, e(0, 0, 0, 4'b0000, 4'b1111, 1, 0)));
        tbl.push_back(v(0, 0, 4'b1111, e(0, 0, 0, 4'b0000, 4'b1111, 1, 1)));
        tbl.push_back(v(1, 0, 4'b0000, Z));

        repeat (2) @(posedge clk);
        #1;
        compare("reset_asserted", Z);
        rst = 1'b0;
        #1;
        compare("reset_released", Z);

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i].clr, tbl[i].arm, tbl[i].pb, tbl[i].exp);
        end

        // Saturating reaction counter
        step("sat_arm", 0, 1, 4'b0000, e(0, 0, 0, 4'b0000, 4'b0000, 1, 0));
        for (int i = 1; i <= 300; i++) begin
            step($sformatf("sat%0d", i), 0, 0, 4'b0000,
                 e(0, 0, 0, 4'b0000, 4'b0000, 1, (i >= 255) ? 8'd255 : 8'(i)));
        end
        step("sat_press", 0, 0, 4'b0010, e(1, 0, 1, 4'b0010, 4'b0000, 0, 255));

        // Asynchronous reset between edges
        rst = 1'b1;
        #2;
        compare("async_rst", Z);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // pb still 0010 vs reset pb_q 1111: no press
        step("post_rst_arm", 0, 1, 4'b0010, e(0, 0, 0, 4'b0000, 4'b0000, 1, 0));
        step("post_rst_win", 0, 0, 4'b0011, e(1, 0, 0, 4'b0001, 4'b0000, 0, 1));

        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, want 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/press_race_arbiter.md
# press_race_arbiter

Parametrised N-player first-press arbiter; successor to the two-button left/right latch in the tug-of-war game. Takes debounced player buttons, detects rising edges, and latches the first press after the round is armed. Reports a single winner, or a tie mask when several players press in the same cycle. Adds false-start lockout and a saturating reaction-time counter. Sits between the button debouncers and the score/LED display logic.

## Interface
- NPLAYERS, 2, number of player buttons (2..16)
- IDXW, 1, winner index width; must be >= clog2(NPLAYERS)
- TW, 8, reaction-time counter width
- FALSE_START, 1, 1 = presses before arm lock that player out for the round; 0 = pre-arm presses ignored, no lockout
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous round clear; returns to IDLE
- arm  in  1  single-cycle go pulse from countdown logic
- pb  in  NPLAYERS  debounced button levels, bit i = player i
- winrnd  out  1  round decided by exactly one player
- tie  out  1  round decided by two or more players in the same cycle
- winner  out  IDXW  lowest set index of winmask
- winmask  out  NPLAYERS  players whose press decided the round
- foul  out  NPLAYERS  players locked out by false start
- armed  out  1  high while in ARMED
- react  out  TW  clock edges from arm to deciding press, saturating

## Operation
- Edge detect: pb_q registers pb each cycle; press[i] = pb[i] & ~pb_q[i]. pb_q resets to all ones, so a button held through reset release is not a press.
- States: IDLE, ARMED, DONE. Reset state IDLE.
- IDLE: if FALSE_START=1, press[i] sets foul[i] (sticky until clr/rst). arm -> ARMED; react loads 0. A press in the same cycle as arm is a foul, not a valid press.
- ARMED: valid = press & ~foul. If valid != 0 -> DONE; winmask <= valid; winrnd <= (popcount(valid)==1); tie <= (popcount(valid)>=2); winner <= lowest set index of valid. react increments on every edge in ARMED, including the deciding edge, saturating at 2^TW-1. Fouled players' presses are ignored. If every player is fouled, the block stays in ARMED until clr.
- DONE: all outputs held; presses and arm ignored.
- arm in ARMED or DONE: ignored (no counter reload).
- clr (any state): -> IDLE; winrnd, tie, winner, winmask, foul, react cleared to 0. clr has priority over arm and presses in the same cycle. pb_q still updates normally.
- winrnd and tie are mutually exclusive; winner is valid only when winrnd|tie.

## Timing
- Reset values: winrnd=0, tie=0, winner=0, winmask=0, foul=0, armed=0, react=0, pb_q=all ones, state IDLE.
- Press latency: a pb rise sampled at edge T in ARMED gives the DONE outputs immediately after edge T (one registered stage, no extra pipeline).
- arm sampled at edge A: armed=1 after A. A deciding press sampled at edge A+n (n>=1) gives react=n.
- Foul latency: a press at edge T in IDLE sets foul after T.
- rst asserted mid-round (ARMED or DONE): all state goes to reset values immediately, with no clock required.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: NPLAYERS=4, IDXW=2, TW=8. Hold pb=0001 through rst release, then arm. Required: all outputs 0 after reset, foul=0000, no win until pb[0] is released and re-pressed.
- Single winner: arm at edge A; pb[2] rises at A+3. Required: winrnd=1, tie=0, winner=2, winmask=0100, react=3, armed=0. A later pb[1] press changes nothing.
- Tie: arm; pb[1] and pb[3] rise in the same cycle. Required: tie=1, winrnd=0, winmask=1010, winner=1.
- False start: pb[0] pulse in IDLE. Required: foul=0001. Then arm; pb[0] re-press is ignored and the block stays ARMED; pb[3] press gives winrnd=1, winner=3, foul still 0001.
- Clear priority: in ARMED, assert clr in the same cycle as a pb[2] rise. Required: state IDLE, winrnd=tie=0, winmask=0, react=0, foul=0. Repeat with clr and arm together: must stay IDLE.
- Saturation and async reset: arm with no press for 300 edges. Required: react=255 and held there; press pb[1] gives react=255, winner=1. Then assert rst between clock edges: outputs go to 0 before the next edge.
